// File: rtl/pb_mem_loader.sv
// Pushbutton-driven memory loader: lets a user enter address/data on hex keys and
// write or read memory directly, taking the memory port away from the CPU meanwhile.
module pb_mem_loader #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              hz100,
  input  logic              reset,
  input  logic [20:0]       pb,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_re,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              cpu_stall,
  output logic              fpga_mode,
  output logic [31:0]       disp_word,
  output logic [3:0]        status
);

  typedef enum logic [2:0] {
    S_CPU, S_ADDR, S_DATA, S_WRITE, S_READ, S_SHOW
  } state_t;

  state_t state, state_nxt;

  logic [20:0]       pb_p0, pb_p1, pb_p2;
  logic [20:0]       edges;
  logic              unused_pb;
  logic [4:0]        dig;
  logic              ev_mode, ev_clear, ev_enter, ev_rw, ev_digit;
  logic [ADDR_W-1:0] addr_sr, addr_reg;
  logic [DATA_W-1:0] data_sr, data_reg, rd_reg;
  logic [15:0]       cnt;
  logic              rw, err, busy, expired;

  function automatic logic [4:0] lowest_digit(input logic [15:0] e);
    logic [4:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--)
      if (e[i]) r = {1'b1, 4'(i)};
    return r;
  endfunction

  // Stage p0/p1: two-flop synchronizer; p2 holds the previous synchronized value
  always_ff @(posedge hz100) begin
    if (reset) begin
      pb_p0 <= '0;
      pb_p1 <= '0;
      pb_p2 <= '0;
    end else begin
      pb_p0 <= pb;
      pb_p1 <= pb_p0;
      pb_p2 <= pb_p1;
    end
  end

  assign edges     = pb_p1 & ~pb_p2;
  assign unused_pb = edges[20];
  assign dig       = lowest_digit(edges[15:0]);

  // At most one event per cycle: MODE > CLEAR > ENTER > RW > digit
  assign ev_mode  = edges[18];
  assign ev_clear = edges[17] & ~edges[18];
  assign ev_enter = edges[16] & ~|edges[18:17];
  assign ev_rw    = edges[19] & ~|edges[18:16];
  assign ev_digit = dig[4] & ~|edges[19:16];

  assign expired = (cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge hz100) begin
    if (reset) state <= S_CPU;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = addr_reg;
    mem_wdata = data_reg;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    fpga_mode = 1'b1;
    busy      = 1'b0;
    disp_word = 32'(addr_sr);
    case (state)
      S_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
        mem_re    = cpu_re;
        fpga_mode = 1'b0;
        disp_word = 32'(cpu_addr);
        if (ev_mode) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        if (ev_mode)       state_nxt = S_CPU;
        else if (ev_enter) state_nxt = rw ? S_READ : S_DATA;
      end
      S_DATA: begin
        disp_word = 32'(data_sr);
        if (ev_mode)       state_nxt = S_CPU;
        else if (ev_enter) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        mem_we    = 1'b1;
        busy      = 1'b1;
        disp_word = 32'(addr_reg);
        if (mem_ack || expired) state_nxt = S_ADDR;
      end
      S_READ: begin
        mem_re    = 1'b1;
        busy      = 1'b1;
        disp_word = 32'(addr_reg);
        if (mem_ack)      state_nxt = S_SHOW;
        else if (expired) state_nxt = S_ADDR;
      end
      S_SHOW: begin
        disp_word = 32'(rd_reg);
        if (ev_mode)       state_nxt = S_CPU;
        else if (ev_clear) state_nxt = S_ADDR;
        else if (ev_enter) state_nxt = S_READ;
      end
      default: state_nxt = S_CPU;
    endcase
  end

  assign cpu_stall = fpga_mode;
  assign status    = {err, rw, fpga_mode, busy};

  always_ff @(posedge hz100) begin
    if (reset) begin
      addr_sr  <= '0;
      addr_reg <= '0;
      data_sr  <= '0;
      data_reg <= '0;
      rd_reg   <= '0;
      cnt      <= '0;
      rw       <= 1'b0;
      err      <= 1'b0;
    end else begin
      cnt <= '0;
      case (state)
        S_CPU: begin
          if (ev_mode) addr_sr <= '0;
        end
        S_ADDR: begin
          if (ev_clear)      addr_sr  <= '0;
          else if (ev_enter) addr_reg <= addr_sr;
          else if (ev_digit) addr_sr  <= {addr_sr[ADDR_W-5:0], dig[3:0]};
          if (ev_rw) rw <= ~rw;
        end
        S_DATA: begin
          if (ev_clear)      data_sr  <= '0;
          else if (ev_enter) data_reg <= data_sr;
          else if (ev_digit) data_sr  <= {data_sr[DATA_W-5:0], dig[3:0]};
          if (ev_rw) rw <= ~rw;
        end
        S_WRITE, S_READ: begin
          if (mem_ack) begin
            err <= 1'b0;
            if (state == S_WRITE) addr_sr <= addr_reg + ADDR_W'(4);
            else                  rd_reg  <= mem_rdata;
          end else if (expired) begin
            err     <= 1'b1;
            addr_sr <= addr_reg;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_SHOW: begin
          if (ev_clear)      addr_sr  <= addr_reg;
          else if (ev_enter) addr_reg <= addr_reg + ADDR_W'(4);
          if (ev_rw) rw <= ~rw;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pb_mem_loader.sv
// Directed bench for pb_mem_loader: a 32-bit instance and an 8-bit instance share stimulus.
module tb_pb_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [20:0] pb;
  logic [31:0] cpu_addr, cpu_wdata, mem_rdata;
  logic        cpu_we, cpu_re, mem_ack;

  logic [31:0] mem_addr, mem_wdata, disp_word;
  logic        mem_we, mem_re, cpu_stall, fpga_mode;
  logic [3:0]  status;

  logic [7:0]  m8_addr, m8_wdata;
  logic        m8_we, m8_re, m8_stall, m8_fpga;
  logic [31:0] m8_disp;
  logic [3:0]  m8_status;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pb_mem_loader #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .hz100(clk), .reset(reset), .pb(pb),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .cpu_stall(cpu_stall), .fpga_mode(fpga_mode), .disp_word(disp_word), .status(status)
  );

  pb_mem_loader #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) dut8 (
    .hz100(clk), .reset(reset), .pb(pb),
    .cpu_addr(cpu_addr[7:0]), .cpu_wdata(cpu_wdata[7:0]), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .mem_rdata(mem_rdata[7:0]), .mem_ack(mem_ack),
    .mem_addr(m8_addr), .mem_wdata(m8_wdata), .mem_we(m8_we), .mem_re(m8_re),
    .cpu_stall(m8_stall), .fpga_mode(m8_fpga), .disp_word(m8_disp), .status(m8_status)
  );

  localparam logic [20:0] K_MODE  = 21'h40000;
  localparam logic [20:0] K_CLEAR = 21'h20000;
  localparam logic [20:0] K_ENTER = 21'h10000;
  localparam logic [20:0] K_RW    = 21'h80000;

  typedef struct {
    logic [20:0] keys;
    logic [31:0] disp;
    logic [3:0]  st;
  } key_vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_we;
    logic        exp_re;
  } cpu_vec_t;

  key_vec_t keytab[16];
  cpu_vec_t cputab[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Idle gap, then hold keys until the loader has acted on the edge.
  task automatic press(input logic [20:0] keys);
    pb = '0;
    tick(2);
    pb = keys;
    tick(3);
    pb = '0;
  endtask

  initial begin
    int we_cycles;

    keytab[0]  = '{K_MODE,           32'h0,        4'h2};
    keytab[1]  = '{21'h00002,        32'h1,        4'h2};
    keytab[2]  = '{21'h00028,        32'h13,       4'h2};
    keytab[3]  = '{K_CLEAR | 21'h80, 32'h0,        4'h2};
    keytab[4]  = '{21'h00002,        32'h1,        4'h2};
    keytab[5]  = '{21'h00001,        32'h10,       4'h2};
    keytab[6]  = '{21'h00001,        32'h100,      4'h2};
    keytab[7]  = '{K_ENTER | 21'h200,32'h0,        4'h2};
    keytab[8]  = '{21'h02000,        32'hD,        4'h2};
    keytab[9]  = '{21'h04000,        32'hDE,       4'h2};
    keytab[10] = '{21'h00400,        32'hDEA,      4'h2};
    keytab[11] = '{21'h02000,        32'hDEAD,     4'h2};
    keytab[12] = '{21'h00800,        32'hDEADB,    4'h2};
    keytab[13] = '{21'h04000,        32'hDEADBE,   4'h2};
    keytab[14] = '{21'h04000,        32'hDEADBEE,  4'h2};
    keytab[15] = '{21'h08000,        32'hDEADBEEF, 4'h2};

    cputab[0] = '{32'h0000_1000, 32'hCAFE_0001, 1'b1, 1'b0, 32'h0000_1000, 32'hCAFE_0001, 1'b1, 1'b0};
    cputab[1] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b1};
    cputab[2] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0};

    reset = 1'b1; pb = '0; mem_ack = 1'b0; mem_rdata = '0;
    cpu_addr = 32'hA5A5_0000; cpu_wdata = 32'h0; cpu_we = 1'b0; cpu_re = 1'b0;
    tick(4);
    chk("reset_status", {28'h0, status}, 32'h0);
    chk("reset_disp_cpu_addr", disp_word, 32'hA5A5_0000);
    reset = 1'b0;
    tick(2);

    for (int i = 0; i < 3; i++) begin
      cpu_addr = cputab[i].addr; cpu_wdata = cputab[i].wdata;
      cpu_we = cputab[i].we; cpu_re = cputab[i].re;
      tick(1);
      chk($sformatf("cpu_vec[%0d] addr", i), mem_addr, cputab[i].exp_addr);
      chk($sformatf("cpu_vec[%0d] wdata", i), mem_wdata, cputab[i].exp_wdata);
      chk($sformatf("cpu_vec[%0d] we_re", i), {30'h0, mem_we, mem_re},
          {30'h0, cputab[i].exp_we, cputab[i].exp_re});
      chk($sformatf("cpu_vec[%0d] stall", i), {31'h0, cpu_stall}, 32'h0);
    end
    cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h0000_0ABC;

    for (int i = 0; i < 16; i++) begin
      press(keytab[i].keys);
      chk($sformatf("key_vec[%0d] disp", i), disp_word, keytab[i].disp);
      chk($sformatf("key_vec[%0d] status", i), {28'h0, status}, {28'h0, keytab[i].st});
    end

    // Write with ack in the third cycle
    press(K_ENTER);
    chk("wr_c1_we", {31'h0, mem_we}, 32'h1);
    chk("wr_c1_re_ignores_cpu", {31'h0, mem_re}, 32'h0);
    chk("wr_addr", mem_addr, 32'h100);
    chk("wr_data", mem_wdata, 32'hDEADBEEF);
    chk("wr_status_busy", {28'h0, status}, 32'h3);
    chk("wr_stall", {31'h0, cpu_stall}, 32'h1);
    tick(1);
    chk("wr_c2_we", {31'h0, mem_we}, 32'h1);
    tick(1);
    chk("wr_c3_we", {31'h0, mem_we}, 32'h1);
    mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    chk("wr_done_we", {31'h0, mem_we}, 32'h0);
    chk("wr_done_disp", disp_word, 32'h104);
    chk("wr_done_status", {28'h0, status}, 32'h2);

    // Read, show, stray ack, auto-step
    press(K_MODE);
    chk("back_to_cpu_status", {28'h0, status}, 32'h0);
    press(K_RW);
    chk("rw_ignored_in_cpu", {28'h0, status}, 32'h0);
    press(K_MODE);
    chk("addr_cleared", disp_word, 32'h0);
    press(K_RW);
    chk("rw_set_status", {28'h0, status}, 32'h6);
    press(21'h00100);
    press(K_ENTER);
    chk("rd_re", {30'h0, mem_we, mem_re}, 32'h1);
    chk("rd_addr", mem_addr, 32'h8);
    chk("rd_status", {28'h0, status}, 32'h7);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick(1);
    mem_ack = 1'b0; mem_rdata = 32'hFFFF_0000;
    chk("show_disp", disp_word, 32'h1234_5678);
    chk("show_status", {28'h0, status}, 32'h6);
    chk("show_re_low", {31'h0, mem_re}, 32'h0);
    mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    chk("show_stray_ack_ignored", disp_word, 32'h1234_5678);
    press(K_ENTER);
    chk("autostep_re", {31'h0, mem_re}, 32'h1);
    chk("autostep_addr", mem_addr, 32'hC);

    // Read timeout, then write timeout
    tick(3);
    chk("rd_c4_re", {31'h0, mem_re}, 32'h1);
    tick(1);
    chk("rd_to_re_low", {31'h0, mem_re}, 32'h0);
    chk("rd_to_status", {28'h0, status}, 32'hE);
    chk("rd_to_disp", disp_word, 32'hC);
    press(K_RW);
    chk("rw_clear_status", {28'h0, status}, 32'hA);
    press(K_ENTER);
    chk("data_kept", disp_word, 32'hDEADBEEF);
    press(K_ENTER);
    we_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_we) we_cycles++;
      tick(1);
    end
    chk("wr_to_we_cycles", we_cycles, 4);
    chk("wr_to_status", {28'h0, status}, 32'hA);
    chk("wr_to_disp", disp_word, 32'hC);

    // Address wrap on the 8-bit instance
    press(K_CLEAR);
    chk("clear_disp", disp_word, 32'h0);
    press(21'h08000);
    press(21'h01000);
    chk("fc_disp8", m8_disp, 32'hFC);
    press(K_ENTER);
    press(K_ENTER);
    chk("fc_wr_addr8", {24'h0, m8_addr}, 32'hFC);
    chk("fc_wr_we8", {31'h0, m8_we}, 32'h1);
    mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    chk("wrap_disp8", m8_disp, 32'h0);
    chk("nowrap_disp32", disp_word, 32'h100);
    chk("wrap_status8", {28'h0, m8_status}, 32'h2);

    // Reset in the middle of a write
    press(K_ENTER);
    press(K_ENTER);
    chk("pre_rst_we", {31'h0, mem_we}, 32'h1);
    cpu_addr = 32'h55; cpu_wdata = 32'h77; cpu_we = 1'b0; cpu_re = 1'b1;
    reset = 1'b1;
    tick(1);
    chk("rst_we_drop", {31'h0, mem_we}, 32'h0);
    chk("rst_re_cpu", {31'h0, mem_re}, 32'h1);
    chk("rst_addr_cpu", mem_addr, 32'h55);
    chk("rst_wdata_cpu", mem_wdata, 32'h77);
    chk("rst_fpga_mode", {31'h0, fpga_mode}, 32'h0);
    chk("rst_status", {28'h0, status}, 32'h0);
    chk("rst_we_drop8", {31'h0, m8_we}, 32'h0);
    chk("rst_addr_cpu8", {24'h0, m8_addr}, 32'h55);
    reset = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
